// File: rtl/des_decrypt_if.sv
// Request/response bundle for the iterative DES decryption core.
interface des_decrypt_if;
  logic        start;
  logic [63:0] desIn;
  logic [63:0] keyIn;
  logic        busy;
  logic        ready;
  logic [63:0] desOut;

  modport master (
    output start, desIn, keyIn,
    input  busy, ready, desOut
  );

  modport slave (
    input  start, desIn, keyIn,
    output busy, ready, desOut
  );
endinterface

// File: rtl/des_decrypt.sv
// Iterative DES decryption: one Feistel round per clock,
// subkeys regenerated each round by rotating C/D right.
module des_decrypt (
  input  logic         clk,
  input  logic         rst_n,
  des_decrypt_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  // Tables use FIPS bit numbering: bit 1 is the MSB.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32};

  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [63:0] ip_fn(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++)
      y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] fp_fn(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++)
      y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_fn(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++)
      y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_fn(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++)
      y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] f_fn(
    input logic [31:0] r,
    input logic [47:0] k
  );
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  b;
    for (int i = 0; i < 48; i++)
      e[6'(47 - i)] = r[5'(32 - E_T[i])];
    e = e ^ k;
    for (int i = 0; i < 8; i++) begin
      b = e[6'(47 - 6 * i) -: 6];
      s[5'(31 - 4 * i) -: 4] =
        4'(SBOX[3'(i)][{b[5], b[0], b[4:1]}]);
    end
    for (int i = 0; i < 32; i++)
      y[5'(31 - i)] = s[5'(32 - P_T[i])];
    return y;
  endfunction

  function automatic logic [1:0] shamt(input logic [4:0] n);
    logic [1:0] s;
    unique case (1'b1)
      (n == 5'd1):  s = 2'd0;
      (n == 5'd2),
      (n == 5'd9),
      (n == 5'd16): s = 2'd1;
      default:      s = 2'd2;
    endcase
    return s;
  endfunction

  function automatic logic [27:0] rotr(
    input logic [27:0] x,
    input logic [1:0]  s
  );
    logic [27:0] y;
    unique case (s)
      2'd1:    y = {x[0], x[27:1]};
      2'd2:    y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  round_q, round_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] out_q, out_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;

  logic [1:0]  sh;
  logic [27:0] c_rot, d_rot;
  logic [47:0] subkey;
  logic [31:0] r_new;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    out_d   = out_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    sh      = shamt(round_q);
    c_rot   = rotr(c_q, sh);
    d_rot   = rotr(d_q, sh);
    subkey  = pc2_fn({c_rot, d_rot});
    r_new   = l_q ^ f_fn(r_q, subkey);
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          {l_d, r_d} = ip_fn(bus.desIn);
          {c_d, d_d} = pc1_fn(bus.keyIn);
          round_d    = 5'd1;
          busy_d     = 1'b1;
          state_d    = ROUND;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      ROUND: begin
        c_d = c_rot;
        d_d = d_rot;
        l_d = r_q;
        r_d = r_new;
        if (round_q == 5'd16) begin
          // No final swap: output block is {R16, L16}.
          out_d   = fp_fn({r_new, r_q});
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          round_d = round_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.ready  = ready_q;
  assign bus.desOut = out_q;

  // Key parity bits never reach PC1.
  logic unused_parity;
  assign unused_parity = ^{bus.keyIn[56], bus.keyIn[48],
                           bus.keyIn[40], bus.keyIn[32],
                           bus.keyIn[24], bus.keyIn[16],
                           bus.keyIn[8],  bus.keyIn[0]};

endmodule

// File: tb/tb_des_decrypt.sv
// Bench for des_decrypt: directed FIPS vectors plus random
// blocks checked against a table-driven DES model via a scoreboard.
module tb_des_decrypt;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  des_decrypt_if bus ();

  des_decrypt u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int ip_t[$] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  int fp_t[$] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
    38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
    36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
    34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  int e_t[$] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,
    12,13,14,15,16,17,16,17,18,19,20,21,20,21,22,23,24,25,
    24,25,26,27,28,29,28,29,30,31,32,1};
  int p_t[$] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int pc1_t[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,
    10,2,59,51,43,35,27,19,11,3,60,52,44,36,
    63,55,47,39,31,23,15,7,62,54,46,38,30,22,
    14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_t[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,
    23,19,12,4,26,8,16,7,27,20,13,2,
    41,52,31,37,47,55,30,40,51,45,33,48,
    44,49,39,56,34,53,46,42,50,36,29,32};
  int ls_t[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int sbox[8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Generic FIPS permutation: output bit j takes input bit t[j].
  function automatic logic [63:0] perm(input logic [63:0] x,
                                       input int nin, input int t[$]);
    logic [63:0] y = '0;
    foreach (t[i]) y = (y << 1) | ((x >> (nin - t[i])) & 64'd1);
    return y;
  endfunction

  function automatic logic [31:0] feist(input logic [31:0] r,
                                        input logic [47:0] k);
    logic [63:0] t;
    logic [47:0] e;
    logic [31:0] s = '0;
    int b, row, col;
    t = perm({32'd0, r}, 32, e_t);
    e = t[47:0] ^ k;
    for (int i = 0; i < 8; i++) begin
      b   = int'((e >> (42 - 6 * i)) & 48'h3f);
      row = ((b >> 4) & 2) | (b & 1);
      col = (b >> 1) & 15;
      s   = (s << 4) | 32'(sbox[i][row * 16 + col]);
    end
    t = perm({32'd0, s}, 32, p_t);
    return t[31:0];
  endfunction

  // Textbook DES: precompute K1..K16 with left shifts, then run
  // the network with the table forwards (encrypt) or backwards.
  function automatic logic [63:0] des_model(input logic [63:0] blk,
                                            input logic [63:0] key,
                                            input bit dec);
    logic [47:0] ks [17];
    logic [27:0] c, d;
    logic [63:0] t;
    logic [31:0] l, r, nr;
    t = perm(key, 64, pc1_t);
    c = t[55:28];
    d = t[27:0];
    ks[0] = '0;
    for (int n = 1; n <= 16; n++) begin
      for (int j = 0; j < ls_t[n-1]; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      t = perm({8'd0, c, d}, 56, pc2_t);
      ks[n] = t[47:0];
    end
    t = perm(blk, 64, ip_t);
    l = t[63:32];
    r = t[31:0];
    for (int n = 1; n <= 16; n++) begin
      nr = l ^ feist(r, dec ? ks[17 - n] : ks[n]);
      l  = r;
      r  = nr;
    end
    return perm({r, l}, 64, fp_t);
  endfunction

  int n_checks = 0;
  int n_errs   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per ready pulse.
  logic        prev_ready = 1'b0;
  logic [63:0] last_out   = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ready <= 1'b0;
      last_out   <= '0;
    end else begin
      if (bus.ready) begin
        check("ready_pulse", {63'd0, prev_ready}, 64'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL spurious_ready act=%h exp=none", bus.desOut);
        end else begin
          check("plaintext", bus.desOut, exp_q.pop_front());
        end
        last_out <= bus.desOut;
      end else if (bus.desOut !== last_out) begin
        check("desOut_hold", bus.desOut, last_out);
      end
      prev_ready <= bus.ready;
    end
  end

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0000000000000000;
  localparam logic [63:0] C2 = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] P2 = 64'h0000000000000000;
  localparam logic [63:0] K3 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C3 = 64'h0000000000000000;
  localparam logic [63:0] P3 = 64'h8787878787878787;

  // Entered #1 after a rising edge with the DUT in IDLE or DONE.
  task automatic run_block(input logic [63:0] key,
                           input logic [63:0] ct,
                           input logic [63:0] pt,
                           input int pulse_at);
    int lat, busy_cnt;
    exp_q.push_back(pt);
    bus.keyIn = key;
    bus.desIn = ct;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.desIn = {$urandom, $urandom};
    bus.keyIn = {$urandom, $urandom};
    busy_cnt  = bus.busy ? 1 : 0;
    lat       = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready) begin
        lat = i;
        break;
      end
      if (bus.busy) busy_cnt++;
      bus.start = (i == pulse_at);
    end
    bus.start = 1'b0;
    check("latency", 64'(lat), 64'd16);
    check("busy_cycles", 64'(busy_cnt), 64'd16);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t1, t2;
    logic [63:0] key, pt, ct;
    bus.start = 1'b0;
    bus.desIn = '0;
    bus.keyIn = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_ready", {63'd0, bus.ready}, 64'd0);
    check("rst_desOut", bus.desOut, 64'd0);
    check("model_enc", des_model(P1, K1, 1'b0), C1);
    check("model_dec", des_model(C1, K1, 1'b1), P1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_block(K1, C1, P1, 0);
    repeat (3) begin @(posedge clk); #1; end
    run_block(K2, C2, P2, 0);
    repeat (2) begin @(posedge clk); #1; end
    run_block(K3, C3, P3, 5);
    repeat (2) begin @(posedge clk); #1; end

    // Back-to-back with start held high.
    exp_q.push_back(P1);
    exp_q.push_back(P2);
    bus.keyIn = K1;
    bus.desIn = C1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    t1 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready) begin t1 = i; break; end
    end
    bus.keyIn = K2;
    bus.desIn = C2;
    t2 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 8) check("b2b_hold", bus.desOut, P1);
      if (bus.ready) begin t2 = i; break; end
    end
    bus.start = 1'b0;
    check("b2b_first", 64'(t1), 64'd16);
    check("b2b_gap", 64'(t2), 64'd17);
    repeat (2) begin @(posedge clk); #1; end

    // Abort mid-block with asynchronous reset.
    exp_q.push_back(P1);
    bus.keyIn = K1;
    bus.desIn = C1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_busy", {63'd0, bus.busy}, 64'd0);
    check("arst_ready", {63'd0, bus.ready}, 64'd0);
    check("arst_desOut", bus.desOut, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_block(K1, C1, P1, 0);

    for (int n = 0; n < 200; n++) begin
      key = {$urandom, $urandom};
      pt  = {$urandom, $urandom};
      ct  = des_model(pt, key, 1'b0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_block(key, ct, pt, int'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++)
      @(negedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
